// File: rtl/lime_tdd_sequencer.sv
// -----------------------------------------------------------------------------
// lime_tdd_sequencer
//
// Time-division sequencer that owns the 8-bit Lime baseband control word.
// It arbitrates level-sensitive RX/TX requests (TX wins) and sequences the
// radio so that the path clock is running before the path is enabled
// (lead interval) and keeps running after the path is disabled (guard
// interval). Each path start issues a one-cycle aclr pulse to the Lime
// interface so it begins from a clean state.
//
// Optional feature (compile-time macro LIME_SEQ_TX_TIMEOUT_EN):
//   TX on-time watchdog. TX_ON is forced into TX_GUARD after max_tx_cycles
//   cycles and the sticky tx_timeout flag masks tx_req until tx_req is seen
//   low. max_tx_cycles = 0 disables the watchdog. Without the macro there is
//   no watchdog counter, max_tx_cycles is ignored and tx_timeout is tied 0.
//
// Ports:
//   clock          DSP clock, all logic on the rising edge
//   reset          synchronous, active-high
//   rx_req/tx_req  level requests for the receive / transmit path
//   rx_mode        copied to rf_ctrl[1:0]
//   tx_mode        copied to rf_ctrl[3:2]
//   clk_lead       extra cycles the clock runs before path enable
//   guard_cycles   extra cycles the clock runs after path disable
//   max_tx_cycles  TX on-time limit (watchdog build only)
//   rf_ctrl        [4] rxen, [5] txen, [6] rxclk en, [7] txclk en, [3:0] modes
//   aclr           one-cycle state-clear pulse on each path start
//   rx_active      high in RX_ON
//   tx_active      high in TX_ON
//   busy           high whenever the sequencer is not IDLE
//   tx_timeout     sticky watchdog flag
//   state_dbg      current FSM state encoding, for observation only
//
// Handshake: rx_req/tx_req are plain levels sampled every clock; there is no
// acknowledge. A request is considered served while its *_active output is
// high, and withdrawn as soon as the level is seen low.
// -----------------------------------------------------------------------------
module lime_tdd_sequencer #(
  parameter int CNT_W = 8,
  parameter int TMO_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx_req,
  input  logic             tx_req,
  input  logic [1:0]       rx_mode,
  input  logic [1:0]       tx_mode,
  input  logic [CNT_W-1:0] clk_lead,
  input  logic [CNT_W-1:0] guard_cycles,
  input  logic [TMO_W-1:0] max_tx_cycles,
  output logic [7:0]       rf_ctrl,
  output logic             aclr,
  output logic             rx_active,
  output logic             tx_active,
  output logic             busy,
  output logic             tx_timeout,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RX_LEAD  = 3'd1,
    S_RX_ON    = 3'd2,
    S_RX_GUARD = 3'd3,
    S_TX_LEAD  = 3'd4,
    S_TX_ON    = 3'd5,
    S_TX_GUARD = 3'd6
  } state_t;

  // Upper nibble of rf_ctrl, packed as {txclk, rxclk, txen, rxen}.
  localparam logic [3:0] CTL_RX_CLK = 4'b0100;
  localparam logic [3:0] CTL_TX_CLK = 4'b1000;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       ctl_nxt;
  logic             aclr_nxt;
  logic             tx_go;       // tx_req after watchdog masking
  logic             tmo_expire;  // watchdog reaches zero this cycle
  logic             tmo_start;   // TX_ON is being entered
  logic             tmo_fire;    // watchdog forces TX_ON -> TX_GUARD

  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ctl_nxt   = rf_ctrl[7:4];
    aclr_nxt  = 1'b0;
    tmo_start = 1'b0;
    tmo_fire  = 1'b0;

    case (state)
      S_IDLE: begin
        if (tx_go) begin
          state_nxt = S_TX_LEAD;
          cnt_nxt   = clk_lead;
          ctl_nxt   = CTL_TX_CLK;
          aclr_nxt  = 1'b1;
        end else if (rx_req) begin
          state_nxt = S_RX_LEAD;
          cnt_nxt   = clk_lead;
          ctl_nxt   = CTL_RX_CLK;
          aclr_nxt  = 1'b1;
        end
      end

      // The lead interval always runs to completion; a request that went
      // away meanwhile skips ON and goes straight to the guard interval.
      S_RX_LEAD: begin
        if (cnt == '0) begin
          if (rx_req) begin
            state_nxt  = S_RX_ON;
            ctl_nxt[0] = 1'b1;
          end else begin
            state_nxt  = S_RX_GUARD;
            ctl_nxt[0] = 1'b0;
            cnt_nxt    = guard_cycles;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end

      // TX pre-empts RX.
      S_RX_ON: begin
        if (tx_go || !rx_req) begin
          state_nxt  = S_RX_GUARD;
          ctl_nxt[0] = 1'b0;
          cnt_nxt    = guard_cycles;
        end
      end

      S_RX_GUARD: begin
        if (cnt == '0) begin
          if (tx_go) begin
            state_nxt = S_TX_LEAD;
            cnt_nxt   = clk_lead;
            ctl_nxt   = CTL_TX_CLK;
            aclr_nxt  = 1'b1;
          end else if (rx_req) begin
            state_nxt = S_RX_LEAD;
            cnt_nxt   = clk_lead;
            ctl_nxt   = CTL_RX_CLK;
            aclr_nxt  = 1'b1;
          end else begin
            state_nxt = S_IDLE;
            ctl_nxt   = 4'b0000;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end

      S_TX_LEAD: begin
        if (cnt == '0) begin
          if (tx_go) begin
            state_nxt  = S_TX_ON;
            ctl_nxt[1] = 1'b1;
            tmo_start  = 1'b1;
          end else begin
            state_nxt  = S_TX_GUARD;
            ctl_nxt[1] = 1'b0;
            cnt_nxt    = guard_cycles;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end

      // rx_req is deliberately ignored while transmitting.
      S_TX_ON: begin
        if (!tx_go || tmo_expire) begin
          state_nxt  = S_TX_GUARD;
          ctl_nxt[1] = 1'b0;
          cnt_nxt    = guard_cycles;
          tmo_fire   = tx_go;
        end
      end

      S_TX_GUARD: begin
        if (cnt == '0) begin
          if (tx_go) begin
            state_nxt = S_TX_LEAD;
            cnt_nxt   = clk_lead;
            ctl_nxt   = CTL_TX_CLK;
            aclr_nxt  = 1'b1;
          end else if (rx_req) begin
            state_nxt = S_RX_LEAD;
            cnt_nxt   = clk_lead;
            ctl_nxt   = CTL_RX_CLK;
            aclr_nxt  = 1'b1;
          end else begin
            state_nxt = S_IDLE;
            ctl_nxt   = 4'b0000;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        ctl_nxt   = 4'b0000;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rf_ctrl   <= 8'h00;
      aclr      <= 1'b0;
      rx_active <= 1'b0;
      tx_active <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rf_ctrl   <= {ctl_nxt, tx_mode, rx_mode};
      aclr      <= aclr_nxt;
      rx_active <= (state_nxt == S_RX_ON);
      tx_active <= (state_nxt == S_TX_ON);
      busy      <= (state_nxt != S_IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // TX on-time watchdog
  // ---------------------------------------------------------------------------
`ifdef LIME_SEQ_TX_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_flag;

  assign tx_go      = tx_req & ~tmo_flag;
  // Expiring at 1 (not 0) makes TX_ON last exactly max_tx_cycles cycles;
  // a load of 0 never reaches 1, which is what disables the watchdog.
  assign tmo_expire = (tmo_cnt == TMO_ONE);
  assign tx_timeout = tmo_flag;

  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (tmo_start) begin
        tmo_cnt <= max_tx_cycles;
      end else if (state == S_TX_ON && tmo_cnt != '0) begin
        tmo_cnt <= tmo_cnt - TMO_ONE;
      end
      if (tmo_fire) begin
        tmo_flag <= 1'b1;
      end else if (!tx_req) begin
        tmo_flag <= 1'b0;
      end
    end
  end
`else
  logic unused_tmo;

  assign tx_go      = tx_req;
  assign tmo_expire = 1'b0;
  assign tx_timeout = 1'b0;
  assign unused_tmo = ^{max_tx_cycles, tmo_start, tmo_fire};
`endif

endmodule

// File: doc/lime_tdd_sequencer.md
Name: lime_tdd_sequencer

Overview:
- Time-division sequencer that owns the 8-bit Lime baseband control word (rx/tx mode, rf_rxen, rf_txen, rf_rxclk/rf_txclk enables) fed into the Lime interface block.
- Arbitrates level-sensitive RX and TX requests from the radio control logic.
- Orders clock-enable before path-enable on turn-on, and path-disable before clock-disable on turn-off, with programmable lead and guard intervals.
- Issues a one-cycle state-clear pulse (aclr) to the interface whenever a path is started.

Parameters:
- CNT_W, 8: width of the lead/guard countdown counter and of the clk_lead/guard_cycles inputs.
- TMO_W, 16: width of the TX on-time watchdog counter and of max_tx_cycles (optional feature only).

Ports:
- clock  input  1  DSP clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high.
- rx_req  input  1  level request for the receive path.
- tx_req  input  1  level request for the transmit path; has priority over rx_req.
- rx_mode  input  2  copied to rf_ctrl[1:0].
- tx_mode  input  2  copied to rf_ctrl[3:2].
- clk_lead  input  CNT_W  extra cycles clock runs before path enable.
- guard_cycles  input  CNT_W  extra cycles clock runs after path disable.
- max_tx_cycles  input  TMO_W  TX on-time limit (used only with the macro).
- rf_ctrl  output  8  control word: [4] rxen, [5] txen, [6] rxclk enable, [7] txclk enable.
- aclr  output  1  one-cycle state-clear pulse to the Lime interface.
- rx_active  output  1  high in RX_ON.
- tx_active  output  1  high in TX_ON.
- busy  output  1  high when state != IDLE.
- tx_timeout  output  1  sticky watchdog flag.

Behaviour:
Reset and outputs
- Reset: state=IDLE, counters=0, rf_ctrl=8'h00, aclr=0, tx_timeout=0.
- All outputs are registered.
- rf_ctrl[3:0] <= {tx_mode, rx_mode} every non-reset cycle.

State machine
- States: IDLE, RX_LEAD, RX_ON, RX_GUARD, TX_LEAD, TX_ON, TX_GUARD.
- IDLE:
  - tx_req -> TX_LEAD.
  - else rx_req -> RX_LEAD.
  - Both asserted -> TX_LEAD.
- Entering *_LEAD:
  - Load counter with clk_lead.
  - Set the matching clock-enable bit.
  - Clear the other path's clock-enable bit.
  - Pulse aclr for exactly one cycle.
- *_LEAD:
  - Decrement each cycle; at 0 -> *_ON, so LEAD lasts clk_lead+1 cycles.
  - Set the path-enable bit (rf_ctrl[4] or rf_ctrl[5]) on entering *_ON.
  - If the request drops during LEAD, still complete LEAD, then go directly to *_GUARD.
- RX_ON:
  - Leave to RX_GUARD when tx_req=1 (pre-emption) or rx_req=0.
- TX_ON:
  - Leave to TX_GUARD when tx_req=0; rx_req is ignored while TX_ON.
- Entering *_GUARD:
  - Clear the path-enable bit.
  - Load counter with guard_cycles.
  - Clock-enable stays set.
- *_GUARD (guard_cycles+1 cycles), exit:
  - tx_req -> TX_LEAD.
  - else rx_req -> RX_LEAD.
  - else -> IDLE.
  - Leaving to IDLE clears the clock-enable bit.
- rf_ctrl[4] and rf_ctrl[5] are never 1 together.
- Clock bits change only on LEAD entry or GUARD exit.

Latency
- Request seen in IDLE at cycle N: rf_ctrl clock bit set at N+1, enable bit at N+2+clk_lead.
- Request drop seen in ON at cycle M: enable bit cleared at M+1, clock bit cleared at M+2+guard_cycles (when next state is IDLE).

Other rules
- clk_lead and guard_cycles are sampled only at counter load; changes mid-interval have no effect.
- Reset mid-sequence returns to IDLE with rf_ctrl=0 on the next edge; no guard interval is applied.

Optional Feature:
LIME_SEQ_TX_TIMEOUT_EN
- Defined:
  - TMO_W counter loads max_tx_cycles on TX_ON entry and decrements in TX_ON.
  - At 0 with tx_req still high: force TX_GUARD and set tx_timeout.
  - While tx_timeout=1, tx_req is treated as 0.
  - tx_timeout clears when tx_req is seen low, or on reset.
  - max_tx_cycles=0 disables the watchdog.
- Undefined:
  - No counter; max_tx_cycles ignored.
  - tx_timeout tied 0.

Test Plan:
- Reset, then rx_req=1, clk_lead=3, rx_mode=2 -> rf_ctrl=0x42 one cycle later; aclr pulses once; rf_ctrl=0x52 four cycles after that; rx_active=1.
- In RX_ON, drop rx_req, guard_cycles=2 -> rf_ctrl=0x42 next cycle, 0x02 three cycles later; busy=0 once IDLE.
- rx_req and tx_req rise the same cycle in IDLE -> TX_LEAD, rf_ctrl[7]=1, rf_ctrl[6]=0; RX path never enabled.
- In RX_ON, raise tx_req -> rxen drops, RX_GUARD, then TX_LEAD with rxclk off, txclk on, second aclr pulse; rf_ctrl[4] and rf_ctrl[5] never both 1.
- Assert reset during TX_GUARD -> rf_ctrl=0x00 and state IDLE on the next edge.
- Macro defined, max_tx_cycles=10, tx_req held -> txen high 10 cycles, then drops; tx_timeout=1; no re-entry until tx_req is low for 1 cycle.
